// File: rtl/grf_wb_sched.sv
// grf_wb_sched: GRF writeback arbiter and pending-MDU-write scoreboard.
// Merges the normal pipeline writeback and long-latency MDU results onto
// a single GRF write port through a one-entry hold buffer. It tracks which
// registers are awaiting an MDU result and stalls issue on hazards against
// them.
// Optional macro GRF_WB_STARVE_GUARD_EN: a held MDU result that has lost
// STARVE_LIMIT consecutive cycles to the pipeline is forced onto the port.
// When this happens, wb_stall asks the pipeline to repeat its writeback.
module grf_wb_sched #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iss_valid,
    input  logic        iss_long,
    input  logic [4:0]  iss_rs,
    input  logic [4:0]  iss_rt,
    input  logic [4:0]  iss_wd,
    output logic        iss_stall,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wreg,
    input  logic [31:0] pipe_data,
    input  logic        mdu_done,
    input  logic [4:0]  mdu_wreg,
    input  logic [31:0] mdu_data,
    output logic        mdu_ack,
    output logic        grf_we,
    output logic [4:0]  grf_wreg,
    output logic [31:0] grf_data,
    output logic [31:0] pend,
    output logic        hold_full,
    output logic        wb_stall
);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

    state_t      state_reg;
    logic [4:0]  hold_wreg_reg;
    logic [31:0] hold_data_reg;
    logic [31:0] pend_reg;
    logic [31:0] pend_next;
    logic [31:0] commit_mask;
    logic [31:0] set_mask;
    logic [31:0] eff;
    logic        sel_hold;
    logic        sel_pipe;
    logic        sel_mdu;
    logic        force_hold;

`ifdef GRF_WB_STARVE_GUARD_EN
    logic [2:0]  loss_reg;

    // The held result is forced out only when it would otherwise lose again.
    assign force_hold = (state_reg == HELD) && (loss_reg == 3'(STARVE_LIMIT)) && pipe_we;
`else
    logic [2:0]  unused_limit;

    assign unused_limit = 3'(STARVE_LIMIT);
    assign force_hold   = 1'b0;
`endif

    // Source selection: forced hold, then pipe, then hold, then direct MDU.
    always_comb begin
        sel_hold = 1'b0;
        sel_pipe = 1'b0;
        sel_mdu  = 1'b0;
        if (!reset) begin
            if (force_hold)
                sel_hold = 1'b1;
            else if (pipe_we)
                sel_pipe = 1'b1;
            else if (state_reg == HELD)
                sel_hold = 1'b1;
            else if (mdu_done)
                sel_mdu = 1'b1;
        end
    end

    // GRF port mux; all-zero when nothing is selected.
    always_comb begin
        grf_we   = sel_hold | sel_pipe | sel_mdu;
        grf_wreg = 5'd0;
        grf_data = 32'd0;
        if (sel_hold) begin
            grf_wreg = hold_wreg_reg;
            grf_data = hold_data_reg;
        end else if (sel_pipe) begin
            grf_wreg = pipe_wreg;
            grf_data = pipe_data;
        end else if (sel_mdu) begin
            grf_wreg = mdu_wreg;
            grf_data = mdu_data;
        end
    end

    // Hazard check sees MDU commits of this cycle as already resolved,
    // since the GRF writes through to the readers in the same cycle.
    always_comb begin
        commit_mask = (sel_hold | sel_mdu) ? (32'd1 << grf_wreg) : 32'd0;
        eff         = pend_reg & ~commit_mask;
        iss_stall   = iss_valid & (eff[iss_rs] | eff[iss_rt] | (iss_long & eff[iss_wd]));
        set_mask    = (iss_valid && !iss_stall && iss_long && (iss_wd != 5'd0))
                      ? (32'd1 << iss_wd) : 32'd0;
        // Set wins over clear; register 0 is never pending.
        pend_next   = ((pend_reg & ~commit_mask) | set_mask) & ~32'd1;
    end

    assign pend      = pend_reg;
    assign hold_full = (state_reg == HELD);
    assign mdu_ack   = (state_reg == EMPTY);
    assign wb_stall  = force_hold & ~reset;

    // Arbiter FSM, starvation counter and pending scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            pend_reg  <= 32'd0;
`ifdef GRF_WB_STARVE_GUARD_EN
            loss_reg  <= 3'd0;
`endif
        end else begin
            pend_reg <= pend_next;
            case (state_reg)
                EMPTY:   if (mdu_done && pipe_we) state_reg <= HELD;
                HELD:    if (sel_hold) state_reg <= EMPTY;
                default: state_reg <= EMPTY;
            endcase
`ifdef GRF_WB_STARVE_GUARD_EN
            if (state_reg == HELD && sel_pipe) begin
                if (loss_reg != 3'd7)
                    loss_reg <= loss_reg + 3'd1;
            end else if (sel_hold || state_reg == EMPTY) begin
                loss_reg <= 3'd0;
            end
`endif
        end
    end

    // Hold buffer capture; contents are only observed while HELD.
    always_ff @(posedge clk) begin
        if (!reset && state_reg == EMPTY && mdu_done && pipe_we) begin
            hold_wreg_reg <= mdu_wreg;
            hold_data_reg <= mdu_data;
        end
    end

endmodule

// File: tb/tb_grf_wb_sched.sv
// Directed testbench for grf_wb_sched. Expected GRF writes are queued when
// stimulus is driven. A negedge monitor pops and compares them as the port
// commits. State and stall outputs are checked inline.
module tb_grf_wb_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid, iss_long;
    logic [4:0]  iss_rs, iss_rt, iss_wd;
    logic        iss_stall;
    logic        pipe_we;
    logic [4:0]  pipe_wreg;
    logic [31:0] pipe_data;
    logic        mdu_done;
    logic [4:0]  mdu_wreg;
    logic [31:0] mdu_data;
    logic        mdu_ack;
    logic        grf_we;
    logic [4:0]  grf_wreg;
    logic [31:0] grf_data;
    logic [31:0] pend;
    logic        hold_full;
    logic        wb_stall;

    int n_assert = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    grf_wb_sched #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_long(iss_long),
        .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_wd(iss_wd),
        .iss_stall(iss_stall),
        .pipe_we(pipe_we), .pipe_wreg(pipe_wreg), .pipe_data(pipe_data),
        .mdu_done(mdu_done), .mdu_wreg(mdu_wreg), .mdu_data(mdu_data),
        .mdu_ack(mdu_ack),
        .grf_we(grf_we), .grf_wreg(grf_wreg), .grf_data(grf_data),
        .pend(pend), .hold_full(hold_full), .wb_stall(wb_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Advance to just after the next rising edge and clear all requests.
    task automatic tick;
        @(posedge clk);
        #1;
        iss_valid = 0; iss_long = 0; iss_rs = 0; iss_rt = 0; iss_wd = 0;
        pipe_we = 0; pipe_wreg = 0; pipe_data = 0;
        mdu_done = 0; mdu_wreg = 0; mdu_data = 0;
    endtask

    task automatic settle;
        #2;
    endtask

    // Scoreboard monitor: every GRF write must match the oldest expectation.
    always @(negedge clk) begin
        if (grf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected grf write", {27'd0, grf_wreg}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wb wreg", {27'd0, grf_wreg}, {27'd0, e[36:32]});
                chk("wb data", grf_data, e[31:0]);
                $display("wb: wreg=%0d data=%08h", grf_wreg, grf_data);
            end
        end
    end

    initial begin
        reset = 1;
        tick();
        tick();
        reset = 0;
        settle();
        chk("rst grf_we", {31'd0, grf_we}, 32'd0);
        chk("rst mdu_ack", {31'd0, mdu_ack}, 32'd1);
        chk("rst hold_full", {31'd0, hold_full}, 32'd0);
        chk("rst iss_stall", {31'd0, iss_stall}, 32'd0);
        chk("rst wb_stall", {31'd0, wb_stall}, 32'd0);
        chk("rst pend", pend, 32'd0);

        // RAW hazard on an MDU destination, cleared in the commit cycle
        tick(); iss_valid = 1; iss_long = 1; iss_wd = 8; iss_rs = 1; iss_rt = 2;
        settle(); chk("issue long 8 stall", {31'd0, iss_stall}, 32'd0);
        tick(); iss_valid = 1; iss_rs = 8; iss_rt = 3; iss_wd = 4;
        settle(); chk("pend 8 set", pend, 32'h100);
        chk("raw stall 1", {31'd0, iss_stall}, 32'd1);
        tick(); iss_valid = 1; iss_rs = 8; iss_rt = 3; iss_wd = 4;
        settle(); chk("raw stall 2", {31'd0, iss_stall}, 32'd1);
        tick(); iss_valid = 1; iss_rs = 8; iss_rt = 3; iss_wd = 4;
        mdu_done = 1; mdu_wreg = 8; mdu_data = 32'h0000_AAAA; expect_wb(8, 32'h0000_AAAA);
        settle(); chk("stall drops on commit", {31'd0, iss_stall}, 32'd0);
        tick(); settle(); chk("pend 8 cleared", pend, 32'd0);

        // Direct zero-latency MDU write from EMPTY
        tick(); iss_valid = 1; iss_long = 1; iss_wd = 9;
        tick(); mdu_done = 1; mdu_wreg = 9; mdu_data = 32'h1234; expect_wb(9, 32'h1234);
        settle();
        chk("direct grf_we", {31'd0, grf_we}, 32'd1);
        chk("direct grf_wreg", {27'd0, grf_wreg}, 32'd9);
        chk("direct grf_data", grf_data, 32'h1234);
        chk("direct pend before", pend, 32'h200);
        tick(); settle(); chk("direct pend after", pend, 32'd0);

        // Collision: pipe wins, MDU result goes to hold and drains next free cycle
        tick(); iss_valid = 1; iss_long = 1; iss_wd = 9;
        tick(); pipe_we = 1; pipe_wreg = 3; pipe_data = 32'h33; expect_wb(3, 32'h33);
        mdu_done = 1; mdu_wreg = 9; mdu_data = 32'h99;
        settle(); chk("collide mdu_ack", {31'd0, mdu_ack}, 32'd1);
        tick(); pipe_we = 1; pipe_wreg = 4; pipe_data = 32'h44; expect_wb(4, 32'h44);
        mdu_done = 1; mdu_wreg = 10; mdu_data = 32'hDEAD;
        settle();
        chk("held hold_full", {31'd0, hold_full}, 32'd1);
        chk("held mdu_ack", {31'd0, mdu_ack}, 32'd0);
        chk("held pend 9", pend, 32'h200);
        tick(); expect_wb(9, 32'h99);
        settle(); chk("drain hold_full", {31'd0, hold_full}, 32'd1);
        tick(); settle();
        chk("drained empty", {31'd0, hold_full}, 32'd0);
        chk("drained pend", pend, 32'd0);

        // Starvation behaviour under continuous pipe writeback
        tick(); pipe_we = 1; pipe_wreg = 3; pipe_data = 32'h1; expect_wb(3, 32'h1);
        mdu_done = 1; mdu_wreg = 12; mdu_data = 32'hC;
        for (int i = 0; i < 4; i++) begin
            tick(); pipe_we = 1; pipe_wreg = 5'(16 + i); pipe_data = 32'h100 + i;
            expect_wb(5'(16 + i), 32'h100 + i);
            settle();
            chk("starve hold_full", {31'd0, hold_full}, 32'd1);
            chk("starve wb_stall", {31'd0, wb_stall}, 32'd0);
        end
`ifdef GRF_WB_STARVE_GUARD_EN
        tick(); pipe_we = 1; pipe_wreg = 20; pipe_data = 32'h200; expect_wb(12, 32'hC);
        settle(); chk("forced wb_stall", {31'd0, wb_stall}, 32'd1);
        tick(); pipe_we = 1; pipe_wreg = 20; pipe_data = 32'h200; expect_wb(20, 32'h200);
        settle();
        chk("forced after hold_full", {31'd0, hold_full}, 32'd0);
        chk("forced after wb_stall", {31'd0, wb_stall}, 32'd0);
`else
        for (int i = 0; i < 4; i++) begin
            tick(); pipe_we = 1; pipe_wreg = 5'(20 + i); pipe_data = 32'h200 + i;
            expect_wb(5'(20 + i), 32'h200 + i);
            settle();
            chk("wait hold_full", {31'd0, hold_full}, 32'd1);
            chk("wait wb_stall", {31'd0, wb_stall}, 32'd0);
        end
        tick(); expect_wb(12, 32'hC);
        settle(); chk("late drain hold_full", {31'd0, hold_full}, 32'd1);
        tick(); settle(); chk("late drained", {31'd0, hold_full}, 32'd0);
`endif

        // wd=0 never pends; set-wins-over-clear on $5; wreg 0 write
        tick(); iss_valid = 1; iss_long = 1; iss_wd = 0;
        tick(); settle(); chk("wd0 pend", pend, 32'd0);
        tick(); iss_valid = 1; iss_long = 1; iss_wd = 5;
        tick(); iss_valid = 1; iss_long = 1; iss_wd = 5;
        mdu_done = 1; mdu_wreg = 5; mdu_data = 32'h55; expect_wb(5, 32'h55);
        settle(); chk("waw through commit", {31'd0, iss_stall}, 32'd0);
        tick(); settle(); chk("set wins pend 5", pend, 32'h20);
        tick(); mdu_done = 1; mdu_wreg = 0; mdu_data = 32'h77; expect_wb(0, 32'h77);
        settle(); chk("wreg0 grf_we", {31'd0, grf_we}, 32'd1);
        tick(); settle(); chk("wreg0 pend kept", pend, 32'h20);
        tick(); mdu_done = 1; mdu_wreg = 5; mdu_data = 32'h56; expect_wb(5, 32'h56);
        tick(); settle(); chk("pend 5 cleared", pend, 32'd0);

        // Reset while HELD discards the held result and the scoreboard
        tick(); iss_valid = 1; iss_long = 1; iss_wd = 9;
        tick(); pipe_we = 1; pipe_wreg = 3; pipe_data = 32'h3; expect_wb(3, 32'h3);
        mdu_done = 1; mdu_wreg = 9; mdu_data = 32'h9;
        tick(); reset = 1;
        settle(); chk("pre-reset hold_full", {31'd0, hold_full}, 32'd1);
        chk("pre-reset pend", pend, 32'h200);
        chk("in-reset grf_we", {31'd0, grf_we}, 32'd0);
        tick(); reset = 0;
        settle();
        chk("post-reset pend", pend, 32'd0);
        chk("post-reset hold_full", {31'd0, hold_full}, 32'd0);
        chk("post-reset grf_we", {31'd0, grf_we}, 32'd0);
        tick(); tick();

        chk("scoreboard empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_wb_sched.md
GRF_WB_SCHED -- requirements
Module: grf_wb_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles a held MDU result may lose arbitration before forced grant.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have ports iss_valid/iss_long, input, 1 each: instruction at issue valid; instruction is long-latency (MDU) with a GRF destination.
REQ-005 SHALL have ports iss_rs/iss_rt/iss_wd, input, 5 each: issuing source registers and destination register.
REQ-006 SHALL have port iss_stall, output, 1: hold issue this cycle (combinational).
REQ-007 SHALL have ports pipe_we (1), pipe_wreg (5), pipe_data (32), inputs: normal pipeline writeback request.
REQ-008 SHALL have ports mdu_done (1), mdu_wreg (5), mdu_data (32), inputs; mdu_ack, output, 1: MDU result offered/accepted.
REQ-009 SHALL have ports grf_we (1), grf_wreg (5), grf_data (32), outputs: the single GRF write port.
REQ-010 SHALL have ports pend (32), output: per-register pending-MDU-write scoreboard; hold_full (1), output; wb_stall (1), output.

Function
REQ-011 Issue accepted = iss_valid & !iss_stall; on accepted iss_long with iss_wd!=0, pend[iss_wd] SHALL set at next edge.
REQ-012 pend[r] SHALL clear at next edge when the GRF port commits r from the MDU path (hold or direct); set on same edge wins over clear.
REQ-013 pend[0] SHALL be constant 0.
REQ-014 iss_stall SHALL = iss_valid & (eff[rs] | eff[rt] | (iss_long & eff[wd])), eff = pend with bit cleared for any register being committed this cycle (GRF write-through supplies data same cycle).
REQ-015 Arbiter states: EMPTY (hold_full=0), HELD (hold_full=1); mdu_ack SHALL = !hold_full.
REQ-016 Priority: forced hold (REQ-020) > pipe > hold > direct mdu_done; at most one GRF write per cycle.
REQ-017 EMPTY: mdu_done with no pipe_we SHALL write directly same cycle (zero latency), stay EMPTY; mdu_done with pipe_we SHALL latch result into hold, go HELD.
REQ-018 HELD: no pipe_we -> write hold, go EMPTY; pipe_we -> pipe writes, stay HELD; mdu_done ignored (mdu_ack=0) until EMPTY.
REQ-019 A committed write with wreg 0 SHALL drive grf_we=1 (GRF discards it) and SHALL not affect pend.
REQ-020 Loss counter (3 bits, saturating) SHALL count consecutive HELD cycles losing to pipe, clear on leaving HELD.
REQ-021 grf_we SHALL be 0 when no source is selected; grf_wreg/grf_data SHALL then be 0.

Reset
REQ-022 On reset edge: pend=0, state EMPTY, loss counter 0; hence grf_we=0, mdu_ack=1, hold_full=0, iss_stall=0, wb_stall=0.
REQ-023 Reset SHALL override every simultaneous issue, writeback and mdu_done; a held result is discarded.
REQ-024 Hold data register need not reset; it SHALL be unobservable while EMPTY.

Configuration
REQ-025 Macro GRF_WB_STARVE_GUARD_EN defined: when loss counter equals STARVE_LIMIT in HELD, hold SHALL win over pipe_we that cycle and wb_stall SHALL be 1 (pipeline repeats its writeback next cycle).
REQ-026 Macro undefined: no forced grant, wb_stall tied 0, counter may be omitted; pipe always wins.

Verification
REQ-027 Issue long iss_wd=8; next cycle issue rs=8 -> iss_stall=1 until MDU commit of $8, stall drops in commit cycle.
REQ-028 EMPTY, mdu_done wreg=9 data=0x1234, pipe_we=0 -> same cycle grf_we=1, grf_wreg=9, grf_data=0x1234, pend[9] clear next edge.
REQ-029 pipe_we wreg=3 and mdu_done wreg=9 same cycle -> $3 written, hold_full=1, mdu_ack=0; next cycle no pipe_we -> $9 written, EMPTY.
REQ-030 With GRF_WB_STARVE_GUARD_EN, HELD and pipe_we continuous -> after 4 losses, hold commits, wb_stall=1 one cycle; without macro, hold waits indefinitely.
REQ-031 Reset asserted while HELD with pend[9]=1 -> next cycle pend=0, hold_full=0, grf_we=0.
REQ-032 Issue long iss_wd=0 -> pend remains 0; issue long iss_wd=5 same cycle as $5 MDU commit -> pend[5]=1 after edge.
